// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALU codes, mux selects,
// FSM states and the latched control word.
package mips_ctrl_pkg;

    localparam int ALUFN_BITS = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08,
                           OP_ADDIU = 6'h09, OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b,
                           OP_ANDI  = 6'h0c, OP_ORI   = 6'h0d, OP_XORI  = 6'h0e,
                           OP_LUI   = 6'h0f, OP_LW    = 6'h23, OP_SW    = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA = 6'h03, F_JR  = 6'h08,
                           F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                           F_AND  = 6'h24, F_OR   = 6'h25, F_XOR = 6'h26, F_NOR  = 6'h27,
                           F_SLT  = 6'h2a, F_SLTU = 6'h2b;

    typedef logic [ALUFN_BITS-1:0] alufn_t;

    localparam alufn_t ALUFN_ADD = 5'd0,  ALUFN_SUB  = 5'd1, ALUFN_AND = 5'd2,
                       ALUFN_OR  = 5'd3,  ALUFN_XOR  = 5'd4, ALUFN_NOR = 5'd5,
                       ALUFN_SLT = 5'd6,  ALUFN_SLTU = 5'd7, ALUFN_SLL = 5'd8,
                       ALUFN_SRL = 5'd9,  ALUFN_SRA  = 5'd10, ALUFN_LUI = 5'd11;

    // Mux orderings shared with the existing datapath.
    localparam logic [1:0] PCSEL_PC4 = 2'b00, PCSEL_BR = 2'b01, PCSEL_J = 2'b10, PCSEL_JR = 2'b11;
    localparam logic [1:0] WA_RD  = 2'b00, WA_RT  = 2'b01, WA_R31 = 2'b10;
    localparam logic [1:0] WD_PC4 = 2'b00, WD_ALU = 2'b01, WD_MEM = 2'b10;
    localparam logic [1:0] AS_REG = 2'b00, AS_SHAMT = 2'b01, AS_C16 = 2'b10;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_JAL, CLS_JR
    } cls_t;

    typedef struct packed {
        logic       werf;
        logic [1:0] wdsel;
        logic [1:0] wasel;
        logic [1:0] asel;
        logic       bsel;
        logic       sext;
        alufn_t     alufn;
        cls_t       cls;
    } ctrl_t;

endpackage

// File: rtl/mips_decode.sv
// Combinational instruction decoder: op/func to the control word the FSM latches in DECODE.
module mips_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output ctrl_t      ctrl,
    output logic       valid
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        ctrl  = '0;
        ctrl.cls = CLS_ALU;
        valid = 1'b1;
        case (op)
            OP_RTYPE: begin
                ctrl.werf  = 1'b1;
                ctrl.wdsel = WD_ALU;
                ctrl.wasel = WA_RD;
                case (func)
                    F_SLL:          begin ctrl.asel = AS_SHAMT; ctrl.alufn = ALUFN_SLL; end
                    F_SRL:          begin ctrl.asel = AS_SHAMT; ctrl.alufn = ALUFN_SRL; end
                    F_SRA:          begin ctrl.asel = AS_SHAMT; ctrl.alufn = ALUFN_SRA; end
                    F_ADD, F_ADDU:  ctrl.alufn = ALUFN_ADD;
                    F_SUB, F_SUBU:  ctrl.alufn = ALUFN_SUB;
                    F_AND:          ctrl.alufn = ALUFN_AND;
                    F_OR:           ctrl.alufn = ALUFN_OR;
                    F_XOR:          ctrl.alufn = ALUFN_XOR;
                    F_NOR:          ctrl.alufn = ALUFN_NOR;
                    F_SLT:          ctrl.alufn = ALUFN_SLT;
                    F_SLTU:         ctrl.alufn = ALUFN_SLTU;
                    F_JR:           begin ctrl.werf = 1'b0; ctrl.cls = CLS_JR; end
                    default:        valid = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.werf  = 1'b1;
                ctrl.wdsel = WD_ALU;
                ctrl.wasel = WA_RT;
                ctrl.bsel  = 1'b1;
                case (op)
                    OP_ADDI, OP_ADDIU: begin ctrl.sext = 1'b1; ctrl.alufn = ALUFN_ADD;  end
                    OP_SLTI:           begin ctrl.sext = 1'b1; ctrl.alufn = ALUFN_SLT;  end
                    OP_SLTIU:          begin ctrl.sext = 1'b1; ctrl.alufn = ALUFN_SLTU; end
                    OP_ANDI:           ctrl.alufn = ALUFN_AND;
                    OP_ORI:            ctrl.alufn = ALUFN_OR;
                    OP_XORI:           ctrl.alufn = ALUFN_XOR;
                    default:           begin ctrl.asel = AS_C16; ctrl.alufn = ALUFN_LUI; end
                endcase
            end
            OP_LW: begin
                ctrl.werf  = 1'b1;
                ctrl.wdsel = WD_MEM;
                ctrl.wasel = WA_RT;
                ctrl.bsel  = 1'b1;
                ctrl.sext  = 1'b1;
                ctrl.alufn = ALUFN_ADD;
                ctrl.cls   = CLS_LOAD;
            end
            OP_SW: begin
                ctrl.bsel  = 1'b1;
                ctrl.sext  = 1'b1;
                ctrl.alufn = ALUFN_ADD;
                ctrl.cls   = CLS_STORE;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.sext  = 1'b1;
                ctrl.alufn = ALUFN_SUB;
                ctrl.cls   = CLS_BRANCH;
            end
            OP_J:   ctrl.cls = CLS_JUMP;
            OP_JAL: begin
                ctrl.werf  = 1'b1;
                ctrl.wdsel = WD_PC4;
                ctrl.wasel = WA_R31;
                ctrl.cls   = CLS_JAL;
            end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory port,
// with a memory-ready timeout and sticky illegal-instruction / bus-error traps.
module mips_mc_controller
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int ALUFN_W     = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               Z,
    input  logic               mem_ready,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pcsel,
    output logic               werf,
    output logic [1:0]         wasel,
    output logic [1:0]         wdsel,
    output logic [1:0]         asel,
    output logic               bsel,
    output logic               sext,
    output logic [ALUFN_W-1:0] alufn,
    output logic               retire,
    output logic               illegal,
    output logic               bus_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_LAST = cnt_t'(MEM_TIMEOUT - 1);

    state_t state_q, state_d;
    ctrl_t  dec_q, dec_d;
    logic   bne_q, bne_d;
    cnt_t   cnt_q, cnt_d;
    logic   illegal_q, illegal_d;
    logic   bus_err_q, bus_err_d;

    ctrl_t  dec_ctrl;
    logic   dec_valid;

    mips_decode u_decode (
        .op    (op),
        .func  (func),
        .ctrl  (dec_ctrl),
        .valid (dec_valid)
    );

    always_comb begin
        state_d   = state_q;
        dec_d     = dec_q;
        bne_d     = bne_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        if (enable) begin
            case (state_q)
                FETCH:  if (mem_ready) state_d = DECODE;
                DECODE: begin
                    if (!dec_valid) begin
                        state_d   = TRAP;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = EXEC;
                        dec_d   = dec_ctrl;
                        bne_d   = (op == OP_BNE);
                    end
                end
                EXEC: begin
                    case (dec_q.cls)
                        CLS_ALU:             state_d = WB;
                        CLS_LOAD, CLS_STORE: state_d = MEM;
                        default:             state_d = FETCH;
                    endcase
                end
                MEM:     if (mem_ready) state_d = (dec_q.cls == CLS_LOAD) ? WB : FETCH;
                WB:      state_d = FETCH;
                default: ;
            endcase
            // A ready on the final allowed wait cycle still completes the access.
            if ((state_q == FETCH || state_q == MEM) && !mem_ready) begin
                if (cnt_q == CNT_LAST) begin
                    state_d   = TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            if (state_d != state_q && (state_d == FETCH || state_d == MEM)) cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q   <= FETCH;
            dec_q     <= '0;
            bne_q     <= 1'b0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dec_q     <= dec_d;
            bne_q     <= bne_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Outputs are gated by reset_n so an access in flight drops in the reset cycle itself.
    always_comb begin
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        ir_we  = 1'b0;
        pc_we  = 1'b0;
        pcsel  = PCSEL_PC4;
        werf   = 1'b0;
        wasel  = WA_RD;
        wdsel  = WD_PC4;
        asel   = AS_REG;
        bsel   = 1'b0;
        sext   = 1'b0;
        alufn  = '0;
        retire = 1'b0;
        if (reset_n) begin
            case (state_q)
                FETCH: begin
                    mem_rd = 1'b1;
                    ir_we  = enable & mem_ready;
                    pc_we  = enable & mem_ready;
                end
                EXEC: begin
                    alufn = ALUFN_W'(dec_q.alufn);
                    asel  = dec_q.asel;
                    bsel  = dec_q.bsel;
                    sext  = dec_q.sext;
                    case (dec_q.cls)
                        CLS_BRANCH: begin
                            pcsel  = PCSEL_BR;
                            pc_we  = enable & (bne_q ? ~Z : Z);
                            retire = enable;
                        end
                        CLS_JUMP: begin
                            pcsel  = PCSEL_J;
                            pc_we  = enable;
                            retire = enable;
                        end
                        CLS_JAL: begin
                            pcsel  = PCSEL_J;
                            pc_we  = enable;
                            werf   = enable;
                            wasel  = WA_R31;
                            wdsel  = WD_PC4;
                            retire = enable;
                        end
                        CLS_JR: begin
                            pcsel  = PCSEL_JR;
                            pc_we  = enable;
                            retire = enable;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    mem_rd = (dec_q.cls == CLS_LOAD);
                    mem_wr = (dec_q.cls == CLS_STORE);
                    retire = enable & mem_ready & (dec_q.cls == CLS_STORE);
                end
                WB: begin
                    werf   = enable & dec_q.werf;
                    wasel  = dec_q.wasel;
                    wdsel  = dec_q.wdsel;
                    retire = enable;
                end
                default: ;
            endcase
        end
        illegal = reset_n & illegal_q;
        bus_err = reset_n & bus_err_q;
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: per-cycle vector table plus a memory-timeout sequence.
module tb_mips_mc_controller;

    localparam int TO = 4;

    localparam logic [5:0] OP_R   = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_LUI = 6'h0f, OP_LW = 6'h23,
                           OP_SW  = 6'h2b, OP_BAD = 6'h3f;
    localparam logic [5:0] FN_SLL = 6'h00, FN_JR = 6'h08, FN_BAD = 6'h3f;
    localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_SLL = 5'd8, A_LUI = 5'd11;

    typedef struct packed {
        logic       reset_n;
        logic       enable;
        logic [5:0] op;
        logic [5:0] func;
        logic       z;
        logic       mem_ready;
    } in_t;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pcsel;
        logic       werf;
        logic [1:0] wasel;
        logic [1:0] wdsel;
        logic [1:0] asel;
        logic       bsel;
        logic       sext;
        logic [4:0] alufn;
        logic       retire;
        logic       illegal;
        logic       bus_err;
    } out_t;

    typedef struct packed {
        in_t  stim;
        out_t want;
    } vec_t;

    logic       clk;
    logic       reset_n, enable, Z, mem_ready;
    logic [5:0] op, func;
    logic       mem_rd, mem_wr, ir_we, pc_we, werf, bsel, sext, retire, illegal, bus_err;
    logic [1:0] pcsel, wasel, wdsel, asel;
    logic [4:0] alufn;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t  vecs[$];
    string tags[$];

    mips_mc_controller #(.MEM_TIMEOUT(TO), .ALUFN_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .op        (op),
        .func      (func),
        .Z         (Z),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pcsel     (pcsel),
        .werf      (werf),
        .wasel     (wasel),
        .wdsel     (wdsel),
        .asel      (asel),
        .bsel      (bsel),
        .sext      (sext),
        .alufn     (alufn),
        .retire    (retire),
        .illegal   (illegal),
        .bus_err   (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: still running at %0t, required finish before 100000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic in_t mk(input logic rn, input logic en, input logic [5:0] o,
                               input logic [5:0] f, input logic z, input logic rdy);
        return {rn, en, o, f, z, rdy};
    endfunction

    function automatic out_t o_none();
        return '0;
    endfunction

    function automatic out_t o_fetch(input logic taken);
        out_t o = '0;
        o.mem_rd = 1'b1;
        o.ir_we  = taken;
        o.pc_we  = taken;
        return o;
    endfunction

    function automatic out_t o_exec(input logic [4:0] fn, input logic [1:0] as,
                                    input logic bs, input logic sx);
        out_t o = '0;
        o.alufn = fn;
        o.asel  = as;
        o.bsel  = bs;
        o.sext  = sx;
        return o;
    endfunction

    function automatic out_t o_xfer(input out_t b, input logic pcw, input logic [1:0] pcs);
        out_t o = b;
        o.pc_we  = pcw;
        o.pcsel  = pcs;
        o.retire = 1'b1;
        return o;
    endfunction

    function automatic out_t o_wb(input logic [1:0] wa, input logic [1:0] wd);
        out_t o = '0;
        o.werf   = 1'b1;
        o.wasel  = wa;
        o.wdsel  = wd;
        o.retire = 1'b1;
        return o;
    endfunction

    function automatic out_t o_mem(input logic rd, input logic wr, input logic ret);
        out_t o = '0;
        o.mem_rd = rd;
        o.mem_wr = wr;
        o.retire = ret;
        return o;
    endfunction

    function automatic out_t o_trap(input logic ill, input logic be);
        out_t o = '0;
        o.illegal = ill;
        o.bus_err = be;
        return o;
    endfunction

    function automatic out_t sample();
        return {mem_rd, mem_wr, ir_we, pc_we, pcsel, werf, wasel, wdsel, asel, bsel, sext,
                alufn, retire, illegal, bus_err};
    endfunction

    task automatic drive(input in_t i);
        reset_n   = i.reset_n;
        enable    = i.enable;
        op        = i.op;
        func      = i.func;
        Z         = i.z;
        mem_ready = i.mem_ready;
    endtask

    task automatic add(input string t, input in_t i, input out_t e);
        vecs.push_back('{stim: i, want: e});
        tags.push_back(t);
    endtask

    // FETCH with immediate ready followed by the strobe-free DECODE cycle.
    task automatic fd(input string t, input logic [5:0] o, input logic [5:0] f, input logic z);
        add({t, "_fetch"},  mk(1, 1, o, f, z, 1), o_fetch(1));
        add({t, "_decode"}, mk(1, 1, o, f, z, 1), o_none());
    endtask

    initial begin
        out_t e;
        int   waits;
        logic seen;

        drive(mk(0, 1, OP_R, 6'h00, 0, 1));

        add("reset_a", mk(0, 1, OP_R, 6'h00, 0, 1), o_none());
        add("reset_b", mk(0, 1, OP_R, 6'h00, 0, 1), o_none());

        fd("addi", OP_ADDI, 6'h00, 0);
        add("addi_exec", mk(1, 1, OP_ADDI, 6'h00, 0, 1), o_exec(A_ADD, 2'b00, 1, 1));
        add("addi_wb",   mk(1, 1, OP_ADDI, 6'h00, 0, 1), o_wb(2'b01, 2'b01));

        fd("sll", OP_R, FN_SLL, 0);
        add("sll_exec", mk(1, 1, OP_R, FN_SLL, 0, 1), o_exec(A_SLL, 2'b01, 0, 0));
        add("sll_wb",   mk(1, 1, OP_R, FN_SLL, 0, 1), o_wb(2'b00, 2'b01));

        fd("lui", OP_LUI, 6'h00, 0);
        add("lui_exec", mk(1, 1, OP_LUI, 6'h00, 0, 1), o_exec(A_LUI, 2'b10, 1, 0));
        add("lui_wb",   mk(1, 1, OP_LUI, 6'h00, 0, 1), o_wb(2'b01, 2'b01));

        fd("lw", OP_LW, 6'h00, 0);
        add("lw_exec",   mk(1, 1, OP_LW, 6'h00, 0, 1), o_exec(A_ADD, 2'b00, 1, 1));
        add("lw_wait1",  mk(1, 1, OP_LW, 6'h00, 0, 0), o_mem(1, 0, 0));
        add("lw_wait2",  mk(1, 1, OP_LW, 6'h00, 0, 0), o_mem(1, 0, 0));
        add("lw_wait3",  mk(1, 1, OP_LW, 6'h00, 0, 0), o_mem(1, 0, 0));
        add("lw_ready",  mk(1, 1, OP_LW, 6'h00, 0, 1), o_mem(1, 0, 0));
        add("lw_wb",     mk(1, 1, OP_LW, 6'h00, 0, 1), o_wb(2'b01, 2'b10));

        fd("beq", OP_BEQ, 6'h00, 1);
        add("beq_z1_exec", mk(1, 1, OP_BEQ, 6'h00, 1, 1), o_xfer(o_exec(A_SUB, 2'b00, 0, 1), 1, 2'b01));
        fd("bne", OP_BNE, 6'h00, 1);
        add("bne_z1_exec", mk(1, 1, OP_BNE, 6'h00, 1, 1), o_xfer(o_exec(A_SUB, 2'b00, 0, 1), 0, 2'b01));
        fd("bne0", OP_BNE, 6'h00, 0);
        add("bne_z0_exec", mk(1, 1, OP_BNE, 6'h00, 0, 1), o_xfer(o_exec(A_SUB, 2'b00, 0, 1), 1, 2'b01));

        fd("j", OP_J, 6'h00, 0);
        add("j_exec", mk(1, 1, OP_J, 6'h00, 0, 1), o_xfer(o_none(), 1, 2'b10));
        fd("jal", OP_JAL, 6'h00, 0);
        e = o_xfer(o_none(), 1, 2'b10);
        e.werf  = 1'b1;
        e.wasel = 2'b10;
        e.wdsel = 2'b00;
        add("jal_exec", mk(1, 1, OP_JAL, 6'h00, 0, 1), e);
        fd("jr", OP_R, FN_JR, 0);
        add("jr_exec", mk(1, 1, OP_R, FN_JR, 0, 1), o_xfer(o_none(), 1, 2'b11));

        // SW: fetch ready on the last allowed wait cycle, then a stalled store.
        add("sw_fwait1", mk(1, 1, OP_SW, 6'h00, 0, 0), o_fetch(0));
        add("sw_fwait2", mk(1, 1, OP_SW, 6'h00, 0, 0), o_fetch(0));
        add("sw_fwait3", mk(1, 1, OP_SW, 6'h00, 0, 0), o_fetch(0));
        add("sw_fready", mk(1, 1, OP_SW, 6'h00, 0, 1), o_fetch(1));
        add("sw_decode", mk(1, 1, OP_SW, 6'h00, 0, 1), o_none());
        add("sw_exec",   mk(1, 1, OP_SW, 6'h00, 0, 1), o_exec(A_ADD, 2'b00, 1, 1));
        add("sw_mwait",  mk(1, 1, OP_SW, 6'h00, 0, 0), o_mem(0, 1, 0));
        add("sw_dis1",   mk(1, 0, OP_SW, 6'h00, 0, 1), o_mem(0, 1, 0));
        add("sw_dis2",   mk(1, 0, OP_SW, 6'h00, 0, 1), o_mem(0, 1, 0));
        add("sw_done",   mk(1, 1, OP_SW, 6'h00, 0, 1), o_mem(0, 1, 1));

        // Disabled fetch, then an illegal opcode and a clearing reset.
        add("fetch_dis",   mk(1, 0, OP_BAD, 6'h00, 0, 1), o_fetch(0));
        fd("badop", OP_BAD, 6'h00, 0);
        add("badop_trap1", mk(1, 1, OP_BAD, 6'h00, 0, 1), o_trap(1, 0));
        add("badop_trap2", mk(1, 1, OP_SW,  6'h00, 0, 1), o_trap(1, 0));
        add("badop_reset", mk(0, 1, OP_R,   6'h00, 0, 1), o_none());
        add("post_reset",  mk(1, 1, OP_R,   FN_BAD, 0, 0), o_fetch(0));
        fd("badfn", OP_R, FN_BAD, 0);
        add("badfn_trap",  mk(1, 1, OP_R, FN_BAD, 0, 1), o_trap(1, 0));
        add("badfn_reset", mk(0, 1, OP_R, FN_BAD, 0, 1), o_none());

        // Reset in the middle of a load access.
        fd("lw2", OP_LW, 6'h00, 0);
        add("lw2_exec",  mk(1, 1, OP_LW, 6'h00, 0, 1), o_exec(A_ADD, 2'b00, 1, 1));
        add("lw2_wait",  mk(1, 1, OP_LW, 6'h00, 0, 0), o_mem(1, 0, 0));
        add("lw2_abort", mk(0, 1, OP_LW, 6'h00, 0, 0), o_none());
        add("lw2_fetch", mk(1, 1, OP_LW, 6'h00, 0, 0), o_fetch(0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].stim);
            #1;
            check(tags[i], 32'(sample()), 32'(vecs[i].want));
        end

        // Fetch timeout: ready never arrives.
        @(negedge clk);
        drive(mk(0, 1, OP_R, 6'h00, 0, 0));
        waits = 0;
        seen  = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            drive(mk(1, 1, OP_R, 6'h00, 0, 0));
            #1;
            if (bus_err) seen = 1'b1;
            else if (mem_rd) waits++;
        end
        check("timeout_bus_err_seen", 32'(seen), 32'd1);
        check("timeout_wait_cycles", 32'(waits), 32'(TO));
        check("timeout_mem_rd_drop", 32'(mem_rd), 32'd0);

        @(negedge clk);
        drive(mk(1, 1, OP_R, 6'h00, 0, 1));
        #1;
        check("trap_absorbs_ready", 32'(sample()), 32'(o_trap(0, 1)));

        @(negedge clk);
        drive(mk(0, 1, OP_R, 6'h00, 0, 1));
        #1;
        check("trap_reset_outputs", 32'(sample()), 32'(o_none()));

        @(negedge clk);
        drive(mk(1, 1, OP_R, 6'h00, 0, 0));
        #1;
        check("trap_cleared_fetch", 32'(sample()), 32'(o_fetch(0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
